// File: rtl/regfile_scoreboard.sv
// Dual-bank (GPR/FPR) register file with a per-register latency scoreboard for decode.
// Operands are read combinationally with writeback forwarding; issue stalls on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          ADDR_W     = 5,
    parameter int unsigned          LAT_W      = 5,
    parameter bit                   ZERO_REG   = 1'b0,
    parameter logic [DATA_W-1:0]    GPR28_INIT = 32'h000f4240,
    parameter logic [DATA_W-1:0]    GPR29_INIT = 32'h00000030
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W:0]   iss_rs,
    input  logic [ADDR_W:0]   iss_rt,
    input  logic              iss_use_s,
    input  logic              iss_use_t,
    input  logic [1:0]        iss_rw,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [LAT_W-1:0]  iss_wait,
    output logic [DATA_W-1:0] rd_s,
    output logic [DATA_W-1:0] rd_t,
    input  logic [1:0]        wb_rw,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              sb_busy
);

    localparam int NTAG  = 2 * (2 ** ADDR_W);
    localparam int TAG_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [NTAG];
    logic [LAT_W-1:0]  cnt  [NTAG];
    logic [NTAG-1:0]   busy;

    logic             wb_en, iss_dest_en, dest_trk, hz, fire;
    logic [TAG_W-1:0] wb_tag, iss_dest_tag;

    // Encoding 11 is treated as "no destination"; bit 1 selects the FPR bank.
    assign wb_en        = (wb_rw == 2'b01) || (wb_rw == 2'b10);
    assign wb_tag       = {wb_rw[1], wb_rd};
    assign iss_dest_en  = (iss_rw == 2'b01) || (iss_rw == 2'b10);
    assign iss_dest_tag = {iss_rw[1], iss_rd};

    always_comb begin
        rd_s = regs[iss_rs];
        if (wb_en && (wb_tag == iss_rs)) rd_s = wb_data;
        if (ZERO_REG && (iss_rs == '0)) rd_s = '0;
    end

    always_comb begin
        rd_t = regs[iss_rt];
        if (wb_en && (wb_tag == iss_rt)) rd_t = wb_data;
        if (ZERO_REG && (iss_rt == '0)) rd_t = '0;
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NTAG; i++) busy[i] = (cnt[i] != '0);
    end

    assign sb_busy   = |busy;
    assign hz        = (iss_use_s && busy[iss_rs]) || (iss_use_t && busy[iss_rt]) ||
                       (iss_dest_en && busy[iss_dest_tag]);
    assign iss_ready = !hz && !flush;
    assign fire      = iss_valid && iss_ready;
    assign dest_trk  = iss_dest_en && (iss_wait != '0) && !(ZERO_REG && (iss_dest_tag == '0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAG; i++) begin
                regs[i] <= (i == 28) ? GPR28_INIT : (i == 29) ? GPR29_INIT : '0;
            end
        end else if (wb_en && !(ZERO_REG && (wb_tag == '0))) begin
            regs[wb_tag] <= wb_data;
        end
    end

    // Issue load beats countdown; flush beats both.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NTAG; i++) begin
                if (flush) begin
                    cnt[i] <= '0;
                end else if (fire && dest_trk && (iss_dest_tag == TAG_W'(i))) begin
                    cnt[i] <= iss_wait;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: expectations are queued when stimulus is driven
// and popped/compared on the following falling edge. A ZERO_REG=1 instance shares the inputs.
module tb_regfile_scoreboard;

    localparam int SEL_READY   = 0;
    localparam int SEL_RD_S    = 1;
    localparam int SEL_RD_T    = 2;
    localparam int SEL_BUSY    = 3;
    localparam int SEL_Z_RD_S  = 4;
    localparam int SEL_Z_BUSY  = 5;
    localparam int SEL_Z_READY = 6;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iss_valid, iss_use_s, iss_use_t, flush;
    logic [5:0]  iss_rs, iss_rt;
    logic [1:0]  iss_rw, wb_rw;
    logic [4:0]  iss_rd, wb_rd, iss_wait;
    logic [31:0] wb_data;
    logic        iss_ready, sb_busy, z_iss_ready, z_sb_busy;
    logic [31:0] rd_s, rd_t, z_rd_s, z_rd_t;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.ZERO_REG(1'b0)) dut (
        .clk(clk), .rstn(rstn), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_s(iss_use_s), .iss_use_t(iss_use_t),
        .iss_rw(iss_rw), .iss_rd(iss_rd), .iss_wait(iss_wait), .rd_s(rd_s), .rd_t(rd_t),
        .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .sb_busy(sb_busy)
    );

    regfile_scoreboard #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rstn(rstn), .iss_valid(iss_valid), .iss_ready(z_iss_ready),
        .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_s(iss_use_s), .iss_use_t(iss_use_t),
        .iss_rw(iss_rw), .iss_rd(iss_rd), .iss_wait(iss_wait), .rd_s(z_rd_s), .rd_t(z_rd_t),
        .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .sb_busy(z_sb_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_READY:   obs = {31'd0, iss_ready};
                SEL_RD_S:    obs = rd_s;
                SEL_RD_T:    obs = rd_t;
                SEL_BUSY:    obs = {31'd0, sb_busy};
                SEL_Z_RD_S:  obs = z_rd_s;
                SEL_Z_BUSY:  obs = {31'd0, z_sb_busy};
                default:     obs = {31'd0, z_iss_ready};
            endcase
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    // Inputs are already set; compare on the falling edge, then cross one rising edge.
    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        iss_use_s = 1'b0;
        iss_use_t = 1'b0;
        iss_rw    = 2'b00;
        iss_rd    = '0;
        iss_wait  = '0;
        wb_rw     = 2'b00;
        wb_rd     = '0;
        wb_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic issue(input logic [1:0] rw, input logic [4:0] rd, input logic [4:0] w);
        iss_valid = 1'b1;
        iss_rw    = rw;
        iss_rd    = rd;
        iss_wait  = w;
    endtask

    initial begin
        rstn   = 1'b0;
        iss_rs = '0;
        iss_rt = '0;
        idle();

        // Reset values
        expect_val("rst_ready", SEL_READY, 32'd1);
        expect_val("rst_busy", SEL_BUSY, 32'd0);
        step();
        rstn   = 1'b1;
        iss_rs = {1'b0, 5'd28};
        iss_rt = {1'b0, 5'd29};
        expect_val("gpr28_init", SEL_RD_S, 32'h000f4240);
        expect_val("gpr29_init", SEL_RD_T, 32'h00000030);
        step();
        iss_rs = {1'b1, 5'd5};
        expect_val("fpr5_init", SEL_RD_S, 32'd0);
        expect_val("post_rst_ready", SEL_READY, 32'd1);
        step();

        // Reset mid-operation drops pending entries
        issue(2'b01, 5'd12, 5'd5);
        step();
        idle();
        expect_val("pend_busy", SEL_BUSY, 32'd1);
        step();
        rstn = 1'b0;
        #1;
        expect_val("midrst_busy", SEL_BUSY, 32'd0);
        step();
        rstn = 1'b1;
        step();

        // Load-use, wait=1
        issue(2'b01, 5'd4, 5'd1);
        expect_val("lu_issue_ready", SEL_READY, 32'd1);
        step();
        issue(2'b00, 5'd0, 5'd0);
        iss_use_s = 1'b1;
        iss_rs    = {1'b0, 5'd4};
        expect_val("lu_stall", SEL_READY, 32'd0);
        expect_val("lu_busy", SEL_BUSY, 32'd1);
        step();
        wb_rw   = 2'b01;
        wb_rd   = 5'd4;
        wb_data = 32'hdeadbeef;
        expect_val("lu_ready", SEL_READY, 32'd1);
        expect_val("lu_fwd", SEL_RD_S, 32'hdeadbeef);
        expect_val("lu_busy_clr", SEL_BUSY, 32'd0);
        step();
        idle();
        expect_val("lu_written", SEL_RD_S, 32'hdeadbeef);
        step();

        // FPU latency 5 with bank separation
        issue(2'b10, 5'd3, 5'd5);
        expect_val("fpu_issue", SEL_READY, 32'd1);
        step();
        issue(2'b00, 5'd0, 5'd0);
        iss_use_s = 1'b1;
        iss_rs    = {1'b1, 5'd3};
        for (int c = 0; c < 5; c++) begin
            expect_val($sformatf("fpu_stall%0d", c), SEL_READY, 32'd0);
            step();
        end
        expect_val("fpu_release", SEL_READY, 32'd1);
        step();
        issue(2'b10, 5'd3, 5'd2);
        iss_use_s = 1'b0;
        step();
        idle();
        iss_use_s = 1'b1;
        iss_use_t = 1'b1;
        iss_rs    = {1'b0, 5'd3};
        iss_rt    = {1'b0, 5'd3};
        expect_val("gpr3_not_stalled", SEL_READY, 32'd1);
        expect_val("fpr3_busy", SEL_BUSY, 32'd1);
        step();
        idle();
        step();
        expect_val("fpu_drained", SEL_BUSY, 32'd0);
        step();

        // WAW + flush
        issue(2'b01, 5'd7, 5'd5);
        expect_val("waw_first", SEL_READY, 32'd1);
        step();
        issue(2'b01, 5'd7, 5'd3);
        expect_val("waw_stall", SEL_READY, 32'd0);
        step();
        flush = 1'b1;
        expect_val("flush_ready", SEL_READY, 32'd0);
        expect_val("flush_busy_pre", SEL_BUSY, 32'd1);
        step();
        flush = 1'b0;
        expect_val("post_flush_ready", SEL_READY, 32'd1);
        expect_val("post_flush_busy", SEL_BUSY, 32'd0);
        step();
        idle();
        flush = 1'b1;
        expect_val("reissue_busy", SEL_BUSY, 32'd1);
        expect_val("flush_blocks", SEL_READY, 32'd0);
        step();
        idle();
        expect_val("flush2_busy", SEL_BUSY, 32'd0);
        step();

        // Forward priority and bank match
        wb_rw   = 2'b01;
        wb_rd   = 5'd9;
        wb_data = 32'h55;
        step();
        idle();
        iss_rs = {1'b0, 5'd9};
        iss_rt = {1'b1, 5'd9};
        expect_val("gpr9_old", SEL_RD_S, 32'h55);
        step();
        wb_rw   = 2'b01;
        wb_rd   = 5'd9;
        wb_data = 32'h1234;
        expect_val("fwd_same_cycle", SEL_RD_S, 32'h1234);
        expect_val("fwd_bank_mismatch", SEL_RD_T, 32'd0);
        step();
        idle();
        expect_val("fwd_after_edge", SEL_RD_S, 32'h1234);
        step();

        // ZERO_REG behaviour
        iss_rs  = '0;
        wb_rw   = 2'b01;
        wb_rd   = 5'd0;
        wb_data = 32'hffffffff;
        expect_val("z_no_fwd", SEL_Z_RD_S, 32'd0);
        expect_val("gpr0_fwd", SEL_RD_S, 32'hffffffff);
        step();
        idle();
        issue(2'b01, 5'd0, 5'd5);
        expect_val("z_no_write", SEL_Z_RD_S, 32'd0);
        expect_val("gpr0_written", SEL_RD_S, 32'hffffffff);
        expect_val("z_issue_ready", SEL_Z_READY, 32'd1);
        step();
        idle();
        expect_val("z_not_tracked", SEL_Z_BUSY, 32'd0);
        expect_val("gpr0_tracked", SEL_BUSY, 32'd1);
        step();
        flush = 1'b1;
        step();
        idle();
        step();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
